// File: rtl/genie_merge_rr_pkg.sv
// Shared definitions for the round-robin packet merge.
// Holds the select-width helper and the lock state encoding.
package genie_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/genie_merge_rr_arb.sv
// Rotating-priority picker: first requester at or after ptr_i,
// found by scanning the request vector doubled and shifted down.
module genie_rr_arb
    import genie_pkg::*;
#(
    parameter  int N    = 2,
    localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_any_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    int             off;
    int             sum;

    assign dbl = {req_i, req_i};
    assign rot = dbl >> ptr_i;

    always_comb begin
        gnt_any_o = |req_i;
        off       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = int'(ptr_i) + off;
        if (sum >= N) sum = sum - N;
        gnt_idx_o = SELW'(sum);
    end

endmodule

// File: rtl/genie_merge_rr.sv
// N-to-1 packet merge with round-robin arbitration and per-packet lock.
// The output stage is a single register with a skid-free load enable.
module genie_merge_rr
    import genie_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDTH = 1,
    localparam int SELW  = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   i_data,
    input  logic [N-1:0]         i_valid,
    input  logic [N-1:0]         i_eop,
    output logic [N-1:0]         o_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    output logic                 o_eop,
    output logic [SELW-1:0]      o_src,
    input  logic                 i_ready
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   lock_q, lock_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              eop_q, eop_d;
    logic [SELW-1:0]   src_q, src_d;

    logic [SELW-1:0]   arb_idx;
    logic              arb_any;
    logic [SELW-1:0]   g;
    logic [SELW-1:0]   g_nxt;
    logic              gnt_any;
    logic              ld;
    logic              xfer;
    logic              gnt_eop;
    logic [WIDTH-1:0]  gnt_data;

    genie_rr_arb #(
        .N (N)
    ) u_arb (
        .req_i     (i_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_any_o (arb_any)
    );

    assign ld       = !valid_q | i_ready;
    assign g        = (state_q == LOCKED) ? lock_q : arb_idx;
    assign gnt_any  = (state_q == LOCKED) | arb_any;
    assign gnt_data = i_data[g*WIDTH +: WIDTH];
    assign gnt_eop  = i_eop[g];
    assign g_nxt    = (int'(g) == N - 1) ? '0 : g + SELW'(1);

    // A locked grant is offered even when the owner has a gap.
    always_comb begin
        o_ready = '0;
        if (!reset && ld && gnt_any) o_ready[g] = 1'b1;
    end

    assign xfer = i_valid[g] & o_ready[g];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        data_d  = data_q;
        valid_d = valid_q;
        eop_d   = eop_q;
        src_d   = src_q;
        if (ld) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = gnt_data;
                eop_d  = gnt_eop;
                src_d  = g;
            end
        end
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_eop) begin
                        ptr_d = g_nxt;
                    end else begin
                        state_d = LOCKED;
                        lock_d  = g;
                    end
                end
                LOCKED: begin
                    if (gnt_eop) begin
                        state_d = IDLE;
                        ptr_d   = g_nxt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eop_q   <= eop_d;
            src_q   <= src_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_eop   = eop_q;
    assign o_src   = src_q;

endmodule

// File: tb/tb_genie_merge_rr.sv
// Bench for genie_merge_rr: directed scenarios with literal output
// sequences plus randomized traffic checked each cycle against a model.
module tb_genie_merge_rr;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_eop;
    logic [N-1:0]   o_ready;
    logic [W-1:0]   o_data;
    logic           o_valid;
    logic           o_eop;
    logic [SELW-1:0] o_src;
    logic           i_ready;

    always #5 clk = ~clk;

    genie_merge_rr #(
        .N     (N),
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_eop   (i_eop),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_eop   (o_eop),
        .o_src   (o_src),
        .i_ready (i_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-source beat queues: bit 8 = eop, bits 7:0 = data.
    int           src_q[N][$];
    logic [N-1:0] hold;
    logic [N-1:0] hs;
    int           out_q[$];
    int           exp_q[$];

    // Reference model state.
    bit m_valid, m_eop, m_locked;
    int m_data, m_src, m_lock, m_ptr;
    bit mdl_ok, mdl_tx, mdl_ld;
    int mdl_g;
    bit cmp_ok;
    int cmp_g;
    logic [N-1:0] cmp_er;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void m_grant(output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (m_locked) begin
            ok = 1'b1;
            g  = m_lock;
        end else begin
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (!ok && i_valid[k]) begin
                    ok = 1'b1;
                    g  = k;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_eop    = 1'b0;
            m_data   = 0;
            m_src    = 0;
            m_locked = 1'b0;
            m_lock   = 0;
            m_ptr    = 0;
        end else begin
            mdl_ld = !m_valid || i_ready;
            m_grant(mdl_ok, mdl_g);
            mdl_tx = mdl_ld && mdl_ok && i_valid[mdl_g];
            if (mdl_ld) m_valid = mdl_tx;
            if (mdl_tx) begin
                m_data = int'(i_data[mdl_g*W +: W]);
                m_eop  = i_eop[mdl_g];
                m_src  = mdl_g;
                if (i_eop[mdl_g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (mdl_g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_lock   = mdl_g;
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp_er = '0;
        if (!reset) begin
            m_grant(cmp_ok, cmp_g);
            if ((!m_valid || i_ready) && cmp_ok) cmp_er[cmp_g] = 1'b1;
        end
        chk("o_ready", o_ready, cmp_er);
        chk("o_valid", o_valid, m_valid);
        if (m_valid) begin
            chk("o_data", o_data, m_data);
            chk("o_eop", o_eop, m_eop);
            chk("o_src", o_src, m_src);
        end
        if (o_valid && i_ready && !reset)
            out_q.push_back(int'(o_src) * 256 + int'(o_data));
        hs = reset ? '0 : (i_valid & o_ready);
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && !hold[k]) begin
                i_valid[k]         = 1'b1;
                i_data[k*W +: W]   = W'(src_q[k][0] & 255);
                i_eop[k]           = ((src_q[k][0] >> 8) & 1) != 0;
            end else begin
                i_valid[k]         = 1'b0;
                i_data[k*W +: W]   = W'($urandom);
                i_eop[k]           = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            if (hs[k]) void'(src_q[k].pop_front());
        drive();
    endtask

    task automatic push_pkt(input int k, input int n, input int base);
        for (int i = 0; i < n; i++)
            src_q[k].push_back(((i == n - 1) ? 256 : 0) + ((base + i) & 255));
    endtask

    function automatic bit busy();
        bit b;
        b = o_valid;
        for (int k = 0; k < N; k++)
            if (src_q[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string nm, input int budget);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            tick();
            c++;
        end
        n_tests++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s drain: still busy after %0d cycles, required idle",
                     nm, c);
        end
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, " len"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({nm, " beat"}, (i < out_q.size()) ? out_q[i] : -1, exp_q[i]);
    endtask

    initial begin
        reset   = 1'b1;
        i_ready = 1'b1;
        hold    = '0;
        i_valid = '0;
        i_data  = '0;
        i_eop   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst o_valid", o_valid, 0);
        chk("rst o_ready", o_ready, 0);
        chk("rst o_src", o_src, 0);
        chk("rst o_data", o_data, 0);
        chk("rst o_eop", o_eop, 0);
        reset = 1'b0;

        // Four single-beat packets, all valid together.
        out_q.delete();
        for (int k = 0; k < N; k++) push_pkt(k, 1, 'hA0 + k);
        drive();
        #1;
        chk("t1 first ready", o_ready, 4'b0001);
        chk("t1 pre valid", o_valid, 0);
        tick();
        chk("t1 lat valid", o_valid, 1);
        chk("t1 lat data", o_data, 'hA0);
        drain("t1", 50);
        exp_q = {32'h0A0, 32'h1A1, 32'h2A2, 32'h3A3};
        chk_seq("t1 order");

        // Three-beat packet on 1 while 2 waits.
        out_q.delete();
        push_pkt(1, 3, 'h10);
        push_pkt(2, 1, 'h20);
        drive();
        drain("t2", 50);
        exp_q = {32'h110, 32'h111, 32'h112, 32'h220};
        chk_seq("t2 lock");

        // Gap inside a locked packet on 0; 3 must wait.
        out_q.delete();
        push_pkt(0, 3, 'h30);
        drive();
        tick();
        hold[0] = 1'b1;
        push_pkt(3, 1, 'h40);
        drive();
        #1;
        chk("t3 gap ready", o_ready, 4'b0001);
        tick();
        chk("t3 gap1 valid", o_valid, 0);
        tick();
        chk("t3 gap2 valid", o_valid, 0);
        hold = '0;
        drive();
        drain("t3", 50);
        exp_q = {32'h030, 32'h031, 32'h032, 32'h340};
        chk_seq("t3 gap");

        // Downstream stall holds the output register.
        out_q.delete();
        push_pkt(1, 2, 'h50);
        drive();
        tick();
        i_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("t4 stall data", o_data, 'h50);
            chk("t4 stall src", o_src, 1);
            chk("t4 stall eop", o_eop, 0);
            chk("t4 stall valid", o_valid, 1);
            chk("t4 stall ready", o_ready, 0);
        end
        i_ready = 1'b1;
        drive();
        drain("t4", 50);
        exp_q = {32'h150, 32'h151};
        chk_seq("t4 stall");

        // Pointer wraps from 3 back to 0.
        out_q.delete();
        push_pkt(3, 1, 'h60);
        drive();
        tick();
        push_pkt(0, 1, 'h61);
        push_pkt(3, 1, 'h62);
        drive();
        #1;
        chk("t5 wrap ready", o_ready, 4'b0001);
        drain("t5", 50);
        exp_q = {32'h360, 32'h061, 32'h362};
        chk_seq("t5 wrap");

        // Reset while locked on 2 with a beat in the output.
        push_pkt(2, 3, 'h70);
        drive();
        tick();
        chk("t6 pre valid", o_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6 rst valid", o_valid, 0);
        chk("t6 rst ready", o_ready, 0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_q.delete();
        push_pkt(1, 1, 'h80);
        push_pkt(2, 1, 'h81);
        drive();
        #1;
        chk("t6 ptr0 ready", o_ready, 4'b0010);
        drain("t6", 50);
        exp_q = {32'h180, 32'h281};
        chk_seq("t6 reset");

        // Randomized traffic against the model.
        repeat (1500) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0 && src_q[k].size() < 8)
                    push_pkt(k, $urandom_range(1, 4), $urandom_range(0, 255));
                hold[k] = ($urandom_range(0, 4) == 0);
            end
            i_ready = ($urandom_range(0, 3) != 0);
            drive();
        end
        reset   = 1'b0;
        hold    = '0;
        i_ready = 1'b1;
        drive();
        drain("rand", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
